// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO.
//
// Operands come straight from the register file (srcA = readData1,
// srcB = readData2). An operation accepted in IDLE runs 32 CALC
// iterations followed by one SIGN cycle that applies sign correction and
// writes HI/LO. done pulses in the cycle the new HI/LO first appear.
//
// Ports:
//   clock_in        rising-edge clock
//   reset           synchronous active-high reset
//   start, op       request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcA, srcB      multiplicand/dividend, multiplier/divisor
//   hiWrite,loWrite MTHI/MTLO strobes, data on writeData (IDLE only)
//   busy            state != IDLE
//   done            one-cycle completion pulse
//   hi, lo          registered HI/LO
//
// Build option: MULDIV_DIV_EN includes the divider. Without it, DIV/DIVU
// are accepted as no-ops that only pulse done.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   aMag, bMag;     // magnitudes (raw for unsigned ops)
  logic [2*WIDTH-1:0] acc;            // product, or quotient in low word
  logic               negRes;         // product / quotient must be negated
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg;
  logic               isSigned;
  logic               runOp;          // start launches a real CALC sequence
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prodFix;

`ifdef MULDIV_DIV_EN
  logic               isDiv;
  logic               negRem;         // remainder follows dividend sign
  logic               bZero;
  logic [WIDTH-1:0]   srcARaw;        // dividend as given, for divide-by-zero
  logic [WIDTH-1:0]   rem;
  logic [WIDTH:0]     divShift;       // 33-bit partial remainder
  logic               qBit;
  logic [WIDTH-1:0]   quotFix, remFix;
`endif

  assign isSigned = ~op[0];
  assign busy     = (state != IDLE);
  assign done     = doneReg;
  assign hi       = hiReg;
  assign lo       = loReg;

`ifdef MULDIV_DIV_EN
  assign runOp = start;
`else
  assign runOp = start & ~op[1];
`endif

  // State register
  always_ff @(posedge clock_in) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (runOp) stateNext = CALC;
      CALC:    if (cnt == CW'(ITER - 1)) stateNext = SIGN;
      SIGN:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Arithmetic for one iteration and the final sign fix-up
  always_comb begin
    // Right-shifting shift-add: add multiplicand into the upper word, then
    // shift the whole accumulator; after ITER steps acc is the product.
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (bMag[0] ? aMag : '0)};
    prodFix = negRes ? -acc : acc;
`ifdef MULDIV_DIV_EN
    // Restoring step: dividend bits are shifted out of aMag's MSB.
    divShift = {rem, aMag[WIDTH-1]};
    qBit     = (divShift >= {1'b0, bMag});
    quotFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix   = negRem ? -rem : rem;
`endif
  end

  // Datapath and architectural registers
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt     <= '0;
      aMag    <= '0;
      bMag    <= '0;
      acc     <= '0;
      negRes  <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
`ifdef MULDIV_DIV_EN
      isDiv   <= 1'b0;
      negRem  <= 1'b0;
      bZero   <= 1'b0;
      srcARaw <= '0;
      rem     <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (runOp) begin
              aMag   <= (isSigned && srcA[WIDTH-1]) ? -srcA : srcA;
              bMag   <= (isSigned && srcB[WIDTH-1]) ? -srcB : srcB;
              negRes <= isSigned && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
              acc    <= '0;
              cnt    <= '0;
`ifdef MULDIV_DIV_EN
              isDiv   <= op[1];
              negRem  <= isSigned && srcA[WIDTH-1];
              bZero   <= (srcB == '0);
              srcARaw <= srcA;
              rem     <= '0;
`endif
            end else begin
              // Divide requested with no divider built: complete at once.
              doneReg <= 1'b1;
            end
          end else begin
            // start has priority over MTHI/MTLO in the same cycle.
            if (hiWrite) hiReg <= writeData;
            if (loWrite) loReg <= writeData;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_EN
          if (isDiv) begin
            rem  <= qBit ? (divShift[WIDTH-1:0] - bMag) : divShift[WIDTH-1:0];
            aMag <= aMag << 1;
            acc  <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qBit};
          end else
`endif
          begin
            acc  <= {mulSum, acc[WIDTH-1:1]};
            bMag <= bMag >> 1;
          end
        end
        SIGN: begin
          cnt     <= '0;
          doneReg <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (isDiv) begin
            if (bZero) begin
              loReg <= '1;
              hiReg <= srcARaw;
            end else begin
              loReg <= quotFix;
              hiReg <= remFix;
            end
          end else
`endif
          begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors; expected HI/LO and done
// cycle are queued at issue time and checked by an independent monitor.
module tb_muldiv_unit;

  logic        clock_in = 1'b0;
  logic        reset, start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] srcA, srcB, writeData;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock_in(clock_in), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .hiWrite(hiWrite), .loWrite(loWrite),
    .writeData(writeData), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] eHi;
    logic [31:0] eLo;
    int          dueCyc;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] curHi = '0;
  logic [31:0] curLo = '0;
  int          lastN;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Monitor: each done pulse retires one queued expectation.
  exp_t mE;
  always @(negedge clock_in) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected done", {63'b0, done}, 64'd0);
      end else begin
        mE = sbq.pop_front();
        check("hi", {32'b0, hi}, {32'b0, mE.eHi});
        check("lo", {32'b0, lo}, {32'b0, mE.eLo});
        check("done cycle", 64'(cyc), 64'(mE.dueCyc));
      end
    end
  end

  // Issue one op; returns #1 after the accept edge with start dropped.
  task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eHi, input logic [31:0] eLo, input bit noop);
    exp_t e;
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clock_in); #1;
    start = 1'b0;
    op = ~o; srcA = ~a; srcB = ~b;   // latched copies must be used
    lastN = cyc;
    e.eHi = eHi; e.eLo = eLo;
    e.dueCyc = noop ? lastN : lastN + 33;
    sbq.push_back(e);
    curHi = eHi; curLo = eLo;
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    while (busy && k < 100) begin
      @(posedge clock_in); #1;
      k++;
    end
    check(name, {63'b0, busy}, 64'd0);
    repeat (2) begin @(posedge clock_in); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] oldHi, oldLo;
    reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
    repeat (2) @(posedge clock_in); #1;
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset hi",   {32'b0, hi}, 64'd0);
    check("reset lo",   {32'b0, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clock_in); #1;

    // MULTU max*max with cycle-exact busy/done
    doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    check("busy after accept", {63'b0, busy}, 64'd1);
    repeat (32) begin @(posedge clock_in); #1; end
    check("busy at N+32", {63'b0, busy}, 64'd1);
    check("no done at N+32", {63'b0, done}, 64'd0);
    check("hi held mid-op", {32'b0, hi}, 64'd0);
    @(posedge clock_in); #1;
    check("busy at N+33", {63'b0, busy}, 64'd0);
    check("done at N+33", {63'b0, done}, 64'd1);
    @(posedge clock_in); #1;
    check("done one cycle", {63'b0, done}, 64'd0);

    // MULT -3*5, stray start mid-op is ignored
    doOp(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    repeat (9) begin @(posedge clock_in); #1; end
    start = 1'b1; op = 2'b01; srcA = 32'd2; srcB = 32'd3;
    @(posedge clock_in); #1;
    start = 1'b0;
    waitIdle("mult idle");

    // MTLO, then MTHI+MTLO together
    loWrite = 1'b1; writeData = 32'h12345678;
    @(posedge clock_in); #1;
    loWrite = 1'b0;
    curLo = 32'h12345678;
    check("mtlo lo", {32'b0, lo}, {32'b0, curLo});
    check("mtlo hi kept", {32'b0, hi}, {32'b0, curHi});
    hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'hCAFEF00D;
    @(posedge clock_in); #1;
    hiWrite = 1'b0; loWrite = 1'b0;
    curHi = 32'hCAFEF00D; curLo = 32'hCAFEF00D;
    check("mthi+mtlo hi", {32'b0, hi}, {32'b0, curHi});
    check("mthi+mtlo lo", {32'b0, lo}, {32'b0, curLo});

    // MTLO while busy has no effect
    oldLo = curLo;
    doOp(2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 0);
    loWrite = 1'b1; writeData = 32'hDEAD0000;
    @(posedge clock_in); #1;
    loWrite = 1'b0;
    check("mtlo while busy", {32'b0, lo}, {32'b0, oldLo});
    waitIdle("multu idle");

    // start coincident with MTHI/MTLO: write dropped
    oldHi = curHi; oldLo = curLo;
    hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'h55555555;
    doOp(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    hiWrite = 1'b0; loWrite = 1'b0;
    check("start wins hi", {32'b0, hi}, {32'b0, oldHi});
    check("start wins lo", {32'b0, lo}, {32'b0, oldLo});
    waitIdle("mult min idle");

`ifdef MULDIV_DIV_EN
    doOp(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    waitIdle("div idle");
    doOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    waitIdle("div ovf idle");
    doOp(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    waitIdle("div neg divisor idle");
    doOp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    waitIdle("divu idle");
    doOp(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 0);
    waitIdle("divu zero idle");
`else
    doOp(2'b11, 32'd7, 32'd0, curHi, curLo, 1);
    check("noop busy", {63'b0, busy}, 64'd0);
    waitIdle("noop idle");
    doOp(2'b10, 32'hFFFFFFF9, 32'd2, curHi, curLo, 1);
    waitIdle("noop2 idle");
`endif

    // Reset mid-operation: aborted, no done
    doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    void'(sbq.pop_back());
    repeat (14) begin @(posedge clock_in); #1; end
    reset = 1'b1;
    @(posedge clock_in); #1;
    reset = 1'b0;
    curHi = '0; curLo = '0;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort hi",   {32'b0, hi}, 64'd0);
    check("abort lo",   {32'b0, lo}, 64'd0);
    doOp(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0);
    waitIdle("post reset idle");

    repeat (40) begin @(posedge clock_in); #1; end
    check("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
